calc_display: RTL and testbench

- Receiving end of the calculator's digit-stream output interface (status/data/pos).
- While the calculator is busy it sends one BCD digit per cycle together with its position. This block captures a complete 8-digit frame into a shadow buffer and commits it atomically to a display buffer.
- It time-multiplexes the display buffer onto 8 common-anode seven-segment displays.
- It overrides the display with "Erro" while the calculator reports error status.

---
 rtl/calc_display.sv | 142 ++++++++++++++
 tb/tb_calc_display.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/calc_display.sv
// Digit-stream receiver for the calculator: captures 8-digit frames into a shadow
// buffer, commits them atomically and scans them onto 8 common-anode seven-segment digits.
module calc_display #(
    parameter int SCAN_DIV    = 100000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_valid
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [7:0][3:0] shadow_r;
    logic [7:0][3:0] display_r;
    logic [7:0]      mask_r;
    logic [CW-1:0]   scan_cnt_r;
    logic [2:0]      scan_idx_r;

    logic [7:0][3:0] shadow_nxt_s;
    logic [7:0]      mask_nxt_s;
    logic            cap_s;
    logic            commit_s;
    logic [6:0]      seg_nxt_s;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] err_to_seg(input logic [2:0] idx);
        logic [6:0] s;
        case (idx)
            3'd0:    s = 7'h23;
            3'd1:    s = 7'h2F;
            3'd2:    s = 7'h2F;
            3'd3:    s = 7'h06;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // A digit above position 0 is blank when it and every digit above it are zero.
    function automatic logic lead_blank(input logic [7:0][3:0] disp, input logic [2:0] idx);
        logic z;
        z = 1'b1;
        for (int k = 0; k < 8; k++) begin
            z = z & ~((k >= int'(idx)) && (disp[k] != 4'd0));
        end
        return (idx != 3'd0) && z;
    endfunction

    // Merge this cycle's capture into shadow/mask and detect the completing write.
    always_comb begin
        cap_s        = (status == 2'b01) && (pos[3] == 1'b0);
        shadow_nxt_s = shadow_r;
        mask_nxt_s   = mask_r;
        if (cap_s) begin
            shadow_nxt_s[pos[2:0]] = data;
            mask_nxt_s[pos[2:0]]   = 1'b1;
        end else begin
            mask_nxt_s = mask_r;
        end
        commit_s = cap_s && (mask_nxt_s == 8'hFF);
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        seg_nxt_s = 7'h7F;
        if (status == 2'b00) begin
            seg_nxt_s = err_to_seg(scan_idx_r);
        end else if (BLANK_ZEROS && lead_blank(display_r, scan_idx_r)) begin
            seg_nxt_s = 7'h7F;
        end else begin
            seg_nxt_s = bcd_to_seg(display_r[scan_idx_r]);
        end
    end

    // Frame capture, abort and atomic commit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_r    <= '0;
            display_r   <= '0;
            mask_r      <= 8'h00;
            frame_valid <= 1'b0;
        end else begin
            shadow_r <= shadow_nxt_s;
            if (commit_s) begin
                display_r   <= shadow_nxt_s;
                mask_r      <= 8'h00;
                frame_valid <= 1'b1;
            end else if (status != 2'b01) begin
                mask_r      <= 8'h00;
                frame_valid <= 1'b0;
            end else begin
                mask_r      <= mask_nxt_s;
                frame_valid <= 1'b0;
            end
        end
    end

    // Scan timing and registered anode/segment drive.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt_r <= '0;
            scan_idx_r <= 3'd0;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            if (scan_cnt_r == CW'(SCAN_DIV - 1)) begin
                scan_cnt_r <= '0;
                scan_idx_r <= scan_idx_r + 3'd1;
            end else begin
                scan_cnt_r <= scan_cnt_r + CW'(1);
            end
            an  <= ~(8'h01 << scan_idx_r);
            seg <= seg_nxt_s;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// Bench for calc_display: two instances (leading-zero blanking on and off) share
// the digit stream; a vector table drives frames and a queue holds expected scan output.
module tb_calc_display;

    localparam int SD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] status = 2'b10;
    logic [3:0] data = 4'd0;
    logic [3:0] pos = 4'd0;
    logic [7:0] an_b, an_n;
    logic [6:0] seg_b, seg_n;
    logic       dp_b, dp_n, fv_b, fv_n;

    int n_cmp = 0;
    int n_bad = 0;
    int fv_cnt = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  st;
        logic [3:0]  ns;
        logic [3:0]  fv;
        logic [55:0] eb;
        logic [55:0] en;
    } vec_t;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] sb;
        logic [6:0] sn;
    } exp_t;

    exp_t sb_q[$];

    calc_display #(.SCAN_DIV(SD), .BLANK_ZEROS(1'b1)) dut (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an_b), .seg(seg_b), .dp(dp_b), .frame_valid(fv_b));

    calc_display #(.SCAN_DIV(SD), .BLANK_ZEROS(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
        .an(an_n), .seg(seg_n), .dp(dp_n), .frame_valid(fv_n));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (fv_b === 1'b1) fv_cnt <= fv_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " an"}, {24'd0, an_b}, 32'hFF);
        chk({nm, " seg"}, {25'd0, seg_b}, 32'h7F);
        chk({nm, " dp"}, {31'd0, dp_b}, 32'h1);
        chk({nm, " fv"}, {31'd0, fv_b}, 32'h0);
        chk({nm, " nb an"}, {24'd0, an_n}, 32'hFF);
    endtask

    // Queue the expected sweep, align to digit 0 and compare one sample per slot.
    task automatic scan_check(input string nm, input logic [55:0] eb, input logic [55:0] en);
        int n;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.an = ~(8'h01 << k);
            e.sb = eb[7*k +: 7];
            e.sn = en[7*k +: 7];
            sb_q.push_back(e);
        end
        repeat (2) @(negedge clock);
        n = 0;
        while (an_b !== 8'hFE && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({nm, " align"}, {24'd0, an_b}, 32'hFE);
        for (int k = 0; k < 8; k++) begin
            e = sb_q.pop_front();
            chk($sformatf("%s an%0d", nm, k), {24'd0, an_b}, {24'd0, e.an});
            chk($sformatf("%s seg%0d", nm, k), {25'd0, seg_b}, {25'd0, e.sb});
            chk($sformatf("%s nb seg%0d", nm, k), {25'd0, seg_n}, {25'd0, e.sn});
            repeat (SD) @(negedge clock);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [3:0] p, input logic [3:0] d);
        status = s;
        pos    = p;
        data   = d;
        @(negedge clock);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int f0;
        f0 = fv_cnt;
        for (int p = int'(v.st); p < int'(v.st) + int'(v.ns); p++) begin
            drive(2'b01, 4'(p), v.d[4*p +: 4]);
        end
        status = 2'b10;
        repeat (3) @(negedge clock);
        chk($sformatf("vec%0d fv pulses", i), fv_cnt - f0, {28'd0, v.fv});
        scan_check($sformatf("vec%0d", i), v.eb, v.en);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h00000123, 4'd0, 4'd8, 4'd1,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30},
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}};
        vecs[1] = '{32'h00055555, 4'd0, 4'd5, 4'd0, vecs[0].eb, vecs[0].en};
        vecs[2] = '{32'h77700000, 4'd5, 4'd3, 4'd0, vecs[0].eb, vecs[0].en};
        vecs[3] = '{32'h99999999, 4'd0, 4'd8, 4'd1, {8{7'h10}}, {8{7'h10}}};
        vecs[4] = '{32'h0000050A, 4'd0, 4'd8, 4'd1,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40, 7'h3F},
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12, 7'h40, 7'h3F}};
        vecs[5] = '{32'h00000000, 4'd0, 4'd8, 4'd1, {{7{7'h7F}}, 7'h40}, {8{7'h40}}};
        vecs[6] = '{32'h12345678, 4'd0, 4'd8, 4'd1,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00},
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[7] = '{32'hF0000000, 4'd0, 4'd8, 4'd1, {7'h3F, {7{7'h40}}}, {7'h3F, {7{7'h40}}}};

        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b1;
        scan_check("post-reset", {{7{7'h7F}}, 7'h40}, {8{7'h40}});

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            if (i == 2) begin
                status = 2'b00;
                scan_check("error", {{4{7'h7F}}, 7'h06, 7'h2F, 7'h2F, 7'h23},
                                    {{4{7'h7F}}, 7'h06, 7'h2F, 7'h2F, 7'h23});
                status = 2'b10;
                scan_check("after error", vecs[0].eb, vecs[0].en);

                for (int p = 0; p < 6; p++) drive(2'b01, 4'(p), 4'd9);
                reset = 1'b0;
                #1;
                chk_reset_outputs("mid-frame reset");
                @(negedge clock);
                chk_reset_outputs("reset held");
                status = 2'b10;
                reset  = 1'b1;
                scan_check("after mid reset", {{7{7'h7F}}, 7'h40}, {8{7'h40}});
            end
        end

        // Exact commit timing, overwrite of a position and ignored positions 8..15.
        drive(2'b01, 4'd0, 4'd5);
        drive(2'b01, 4'd1, 4'd0);
        drive(2'b01, 4'd9, 4'd7);
        drive(2'b01, 4'd8, 4'd6);
        drive(2'b01, 4'd0, 4'd4);
        for (int p = 2; p < 7; p++) drive(2'b01, 4'(p), 4'd0);
        chk("fv before last", {31'd0, fv_b}, 32'h0);
        drive(2'b01, 4'd7, 4'd0);
        status = 2'b10;
        chk("fv pulse", {31'd0, fv_b}, 32'h1);
        @(negedge clock);
        chk("fv one cycle", {31'd0, fv_b}, 32'h0);
        scan_check("overwrite", {{7{7'h7F}}, 7'h19}, {{7{7'h40}}, 7'h19});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
